// File: rtl/mips_pipe_pkg.sv
// Shared encodings for the MIPS pipeline fetch side and the hazard unit.
// Holds next-PC select codes, the NOP instruction word and the default reset PC.
// Pure declarations; no logic, no latency, no flow control.
package mips_pipe_pkg;

  // Next-PC source select driven by the hazard unit.
  localparam logic [1:0] ADDR_SEQ     = 2'b00;
  localparam logic [1:0] ADDR_JUMP    = 2'b01;
  localparam logic [1:0] ADDR_BRANCH  = 2'b10;
  localparam logic [1:0] ADDR_ILLEGAL = 2'b11;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones.
// Latency: count reflects an enabled cycle one posedge later.
// Backpressure: none; en is sampled every cycle.
//   clk   in  clock
//   rst   in  synchronous active-high clear
//   en    in  count this cycle
//   count out current value, saturates at 16'hFFFF
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 16'h0000;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, next-PC select, IF/ID register and ID/EX control register.
// Latency: PC redirect visible right after the sampling edge; fetched word lands in IF/ID one edge later.
// Backpressure: obeys PC_Write/IF_Write stall and flush commands and bubble from the hazard unit.
//   Clk, Rst                       clock and synchronous active-high reset
//   PC_Write, IF_Write, bubble     hazard unit commands
//   addrSel, jumpTarget, branchTarget  next-PC source select and targets
//   imemAddr/imemData              combinational instruction memory port
//   instrID, pcPlus4ID, validID    IF/ID register
//   ctrlID/ctrlEX                  decoded control in, ID/EX control register out
//   stallCount, flushCount, illegalSel  debug counters and sticky illegal flag
module fetch_unit
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CTRL_W   = 12
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              PC_Write,
  input  logic              IF_Write,
  input  logic              bubble,
  input  logic [1:0]        addrSel,
  input  logic [31:0]       jumpTarget,
  input  logic [31:0]       branchTarget,
  output logic [31:0]       imemAddr,
  input  logic [31:0]       imemData,
  output logic [31:0]       instrID,
  output logic [31:0]       pcPlus4ID,
  output logic              validID,
  input  logic [CTRL_W-1:0] ctrlID,
  output logic [CTRL_W-1:0] ctrlEX,
  output logic [15:0]       stallCount,
  output logic [15:0]       flushCount,
  output logic              illegalSel
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        illegal_now;
  logic        stall_en;
  logic        flush_en;

  // Target low bits are dropped: PC stays word aligned.
  logic        unused_tgt_lsbs;
  assign unused_tgt_lsbs = ^{jumpTarget[1:0], branchTarget[1:0]};

  assign imemAddr    = pc;
  assign pc_plus4    = pc + 32'd4;
  assign illegal_now = PC_Write && (addrSel == ADDR_ILLEGAL);

  // {0,1} is not a legal hazard command; it is treated as a stall.
  assign stall_en = !PC_Write;
  assign flush_en = PC_Write && !IF_Write;

  always_comb begin
    next_pc = pc;
    case (addrSel)
      ADDR_SEQ:    next_pc = pc_plus4;
      ADDR_JUMP:   next_pc = {jumpTarget[31:2], 2'b00};
      ADDR_BRANCH: next_pc = {branchTarget[31:2], 2'b00};
      default:     next_pc = pc;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc         <= RESET_PC;
      instrID    <= NOP_INSTR;
      pcPlus4ID  <= 32'h0;
      validID    <= 1'b0;
      ctrlEX     <= '0;
      illegalSel <= 1'b0;
    end else begin
      if (PC_Write) begin
        pc <= next_pc;
      end

      if (PC_Write && IF_Write) begin
        instrID   <= imemData;
        pcPlus4ID <= pc_plus4;
        validID   <= 1'b1;
      end else if (PC_Write) begin
        // Flush squashes the wrong-path instruction; pcPlus4ID is left as is.
        instrID <= NOP_INSTR;
        validID <= 1'b0;
      end

      // Bubble insertion is independent of the IF/ID command.
      ctrlEX <= bubble ? '0 : ctrlID;

      if (illegal_now) begin
        illegalSel <= 1'b1;
      end
    end
  end

  sat_counter16 u_stall_cnt (
    .clk   (Clk),
    .rst   (Rst),
    .en    (stall_en),
    .count (stallCount)
  );

  sat_counter16 u_flush_cnt (
    .clk   (Clk),
    .rst   (Rst),
    .en    (flush_en),
    .count (flushCount)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed hazard scenarios plus random commands
// checked against a behavioural model of the fetch stage.
// Latency: checks every output #1 after each posedge.
module tb_fetch_unit;

  logic        Clk;
  logic        Rst;
  logic        PC_Write;
  logic        IF_Write;
  logic        bubble;
  logic [1:0]  addrSel;
  logic [31:0] jumpTarget;
  logic [31:0] branchTarget;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic [31:0] instrID;
  logic [31:0] pcPlus4ID;
  logic        validID;
  logic [11:0] ctrlID;
  logic [11:0] ctrlEX;
  logic [15:0] stallCount;
  logic [15:0] flushCount;
  logic        illegalSel;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pcp4;
  logic        m_valid, m_ill;
  logic [11:0] m_ctrl;
  int          m_stall, m_flush;

  fetch_unit #(.RESET_PC(32'h0000_0000), .CTRL_W(12)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .PC_Write     (PC_Write),
    .IF_Write     (IF_Write),
    .bubble       (bubble),
    .addrSel      (addrSel),
    .jumpTarget   (jumpTarget),
    .branchTarget (branchTarget),
    .imemAddr     (imemAddr),
    .imemData     (imemData),
    .instrID      (instrID),
    .pcPlus4ID    (pcPlus4ID),
    .validID      (validID),
    .ctrlID       (ctrlID),
    .ctrlEX       (ctrlEX),
    .stallCount   (stallCount),
    .flushCount   (flushCount),
    .illegalSel   (illegalSel)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Instruction memory: an address-dependent, mostly nonzero word.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  assign imemData = imem(imemAddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imemAddr",   imemAddr,                   m_pc);
    chk("instrID",    instrID,                    m_instr);
    chk("pcPlus4ID",  pcPlus4ID,                  m_pcp4);
    chk("validID",    {31'b0, validID},           {31'b0, m_valid});
    chk("ctrlEX",     {20'b0, ctrlEX},            {20'b0, m_ctrl});
    chk("stallCount", {16'b0, stallCount},        m_stall);
    chk("flushCount", {16'b0, flushCount},        m_flush);
    chk("illegalSel", {31'b0, illegalSel},        {31'b0, m_ill});
  endtask

  // Drive one cycle of inputs, advance the model by the architectural rules,
  // then clock and optionally compare.
  task automatic step(input logic r, input logic pw, input logic iw, input logic bub,
                      input logic [1:0] sel, input logic [31:0] jt, input logic [31:0] bt,
                      input logic [11:0] ctl, input bit do_chk);
    logic [31:0] seq;
    Rst = r; PC_Write = pw; IF_Write = iw; bubble = bub;
    addrSel = sel; jumpTarget = jt; branchTarget = bt; ctrlID = ctl;
    if (r) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
      m_ctrl = 12'h0; m_stall = 0; m_flush = 0; m_ill = 1'b0;
    end else begin
      seq = m_pc + 32'd4;
      if (pw && iw) begin
        m_instr = imem(m_pc); m_pcp4 = seq; m_valid = 1'b1;
      end else if (pw) begin
        m_instr = 32'h0; m_valid = 1'b0;
      end
      if (!pw) begin
        if (m_stall < 65535) m_stall++;
      end else if (!iw) begin
        if (m_flush < 65535) m_flush++;
      end
      if (pw) begin
        if (sel == 2'd0)      m_pc = seq;
        else if (sel == 2'd1) m_pc = jt & 32'hFFFF_FFFC;
        else if (sel == 2'd2) m_pc = bt & 32'hFFFF_FFFC;
        else                  m_ill = 1'b1;
      end
      m_ctrl = bub ? 12'h0 : ctl;
    end
    @(posedge Clk);
    #1;
    if (do_chk) check_all();
  endtask

  initial begin
    Rst = 1'b1; PC_Write = 1'b0; IF_Write = 1'b0; bubble = 1'b0;
    addrSel = 2'b00; jumpTarget = 32'h0; branchTarget = 32'h0; ctrlID = 12'h0;

    // Reset overrides a redirect that is present on the inputs.
    step(1, 1, 1, 0, 2'b01, 32'h1234_5678, 32'h0, 12'hABC, 1);
    chk("reset_pc", imemAddr, 32'h0);

    // Sequential fetch from reset.
    step(0, 1, 1, 0, 2'b00, 32'h0, 32'h0, 12'h111, 1);
    chk("seq_pc4", imemAddr, 32'h4);
    chk("seq_instr0", instrID, imem(32'h0));
    step(0, 1, 1, 0, 2'b00, 32'h0, 32'h0, 12'h222, 1);
    step(0, 1, 1, 0, 2'b00, 32'h0, 32'h0, 12'h333, 1);
    chk("seq_pcC", imemAddr, 32'hC);
    chk("seq_valid", {31'b0, validID}, 32'h1);

    // Jump with misaligned target flushes IF/ID.
    step(0, 1, 0, 0, 2'b01, 32'h0000_0403, 32'h0, 12'h444, 1);
    chk("jump_pc", imemAddr, 32'h400);
    chk("jump_flushcnt", {16'b0, flushCount}, 32'h1);

    // Load-use stall with bubble at PC=0x10.
    step(1, 0, 0, 0, 2'b00, 32'h0, 32'h0, 12'h0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 2'b00, 32'h0, 32'h0, 12'h5A5, 1);
    step(0, 0, 0, 1, 2'b10, 32'h0, 32'h0000_0900, 12'h777, 1);
    chk("stall_pc", imemAddr, 32'h10);
    chk("stall_ctrl", {20'b0, ctrlEX}, 32'h0);
    chk("stall_cnt", {16'b0, stallCount}, 32'h1);
    step(0, 1, 1, 0, 2'b00, 32'h0, 32'h0, 12'h0F0, 1);
    chk("release_pc", imemAddr, 32'h14);

    // Taken branch with bubble.
    step(0, 1, 0, 1, 2'b10, 32'h0, 32'h0000_0080, 12'hFFF, 1);
    chk("branch_pc", imemAddr, 32'h80);

    // {0,1} is held like a stall.
    step(0, 0, 1, 0, 2'b00, 32'h0, 32'h0, 12'h00F, 1);

    // Wrap at the top of the address space.
    step(0, 1, 1, 0, 2'b01, 32'hFFFF_FFFF, 32'h0, 12'h001, 1);
    step(0, 1, 1, 0, 2'b00, 32'h0, 32'h0, 12'h002, 1);
    chk("wrap_pc", imemAddr, 32'h0);
    chk("wrap_pcp4", pcPlus4ID, 32'h0);

    // Illegal select holds PC and sets the sticky flag.
    step(0, 1, 1, 0, 2'b11, 32'h0, 32'h0, 12'h003, 1);
    chk("illegal_set", {31'b0, illegalSel}, 32'h1);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 2'b00, 32'h0, 32'h0, 12'h004, 1);
    chk("illegal_sticky", {31'b0, illegalSel}, 32'h1);

    // Random hazard commands with occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
           2'($urandom), $urandom, $urandom, 12'($urandom), 1);
    end

    // Stall long enough to saturate the stall counter.
    step(1, 0, 0, 0, 2'b00, 32'h0, 32'h0, 12'h0, 1);
    for (int i = 0; i < 65540; i++) begin
      step(0, 0, 0, 0, 2'($urandom), $urandom, $urandom, 12'($urandom),
           (i % 8192 == 0) || (i >= 65530));
    end
    chk("sat_stall", {16'b0, stallCount}, 32'h0000_FFFF);

    // Reset mid-stall with a pending branch target.
    step(0, 0, 0, 1, 2'b10, 32'h0, 32'h0000_0CC0, 12'h0, 1);
    step(1, 0, 0, 0, 2'b10, 32'h0, 32'h0000_0CC0, 12'h0, 1);
    chk("rst_stall_cnt", {16'b0, stallCount}, 32'h0);
    step(0, 1, 1, 0, 2'b00, 32'h0, 32'h0, 12'h0, 1);
    chk("post_rst_fetch", instrID, imem(32'h0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
